// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: write-port scheduler for the 32x32 MIPS register file.
// After reset, or on a clear request, it sweeps every register to INIT_VAL.
// Otherwise it shares the single write port between two valid/ready requesters
// using round-robin arbitration. With SKIP_R0 set, address 0 is never written.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   a_valid/a_addr/a_data      requester A (pipeline write-back) write request
//   a_ready                    A transfer accepted this cycle (combinational)
//   b_valid/b_addr/b_data      requester B (debug/loader) write request
//   b_ready                    B transfer accepted this cycle (combinational)
//   clr_req                    one-cycle request to re-sweep all registers
//   init_done                  high while arbitrating
//   busy                       high while sweeping (or about to sweep)
//   RegWr/rd/busW              registered register-file write port
//   gnt_b                      registered, 1 = current write came from B
module regfile_wr_sched #(
   parameter int unsigned     AW       = 5,
   parameter int unsigned     DW       = 32,
   parameter logic [DW-1:0]   INIT_VAL = '0,
   parameter bit              SKIP_R0  = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   input  logic          clr_req,
   output logic          init_done,
   output logic          busy,
   output logic          RegWr,
   output logic [AW-1:0] rd,
   output logic [DW-1:0] busW,
   output logic          gnt_b
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_ARB   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   localparam logic [AW-1:0] CNT_LAST = '1;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          rr_last_b_q, rr_last_b_d;   // 1 = B won the last transfer
   logic          regwr_d;
   logic [AW-1:0] rd_d;
   logic [DW-1:0] busw_d;
   logic          gnt_b_d;

   // State register and registered write-port outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         rr_last_b_q <= 1'b1;
         RegWr       <= 1'b0;
         rd          <= '0;
         busW        <= '0;
         gnt_b       <= 1'b0;
         busy        <= 1'b1;
         init_done   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_last_b_q <= rr_last_b_d;
         RegWr       <= regwr_d;
         rd          <= rd_d;
         busW        <= busw_d;
         gnt_b       <= gnt_b_d;
         busy        <= (state_d != ST_ARB);
         init_done   <= (state_d == ST_ARB);
      end
   end

   // Next state, arbitration and next write-port values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_last_b_d = rr_last_b_q;
      regwr_d     = 1'b0;
      rd_d        = rd;
      busw_d      = busW;
      gnt_b_d     = gnt_b;
      a_ready     = 1'b0;
      b_ready     = 1'b0;

      case (state_q)
         ST_INIT, ST_CLEAR: begin
            // Sweep one register per cycle; clr_req is ignored here
            rd_d    = cnt_q;
            busw_d  = INIT_VAL;
            gnt_b_d = 1'b0;
            regwr_d = !(SKIP_R0 && (cnt_q == '0));
            cnt_d   = cnt_q + AW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_ARB;
            end
         end
         ST_ARB: begin
            if (clr_req) begin
               // Clear wins over any request; sweep starts on the next edge
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end else begin
               // On contention the requester that did not win last time goes
               a_ready = a_valid && (!b_valid || rr_last_b_q);
               b_ready = b_valid && (!a_valid || !rr_last_b_q);
               if (a_ready) begin
                  rd_d        = a_addr;
                  busw_d      = a_data;
                  gnt_b_d     = 1'b0;
                  regwr_d     = !(SKIP_R0 && (a_addr == '0));
                  rr_last_b_d = 1'b0;
               end else if (b_ready) begin
                  rd_d        = b_addr;
                  busw_d      = b_data;
                  gnt_b_d     = 1'b1;
                  regwr_d     = !(SKIP_R0 && (b_addr == '0));
                  rr_last_b_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Self-checking bench for regfile_wr_sched: a small reference model pushes the
// expected write-port state into a scoreboard before each edge and pops it
// after the edge for comparison.
module tb_regfile_wr_sched;

   logic        clk;
   logic        rst_n;
   logic        a_valid, b_valid, clr_req;
   logic        a_ready, b_ready;
   logic [4:0]  a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic        init_done, busy, RegWr, gnt_b;
   logic [4:0]  rd;
   logic [31:0] busW;

   typedef struct {
      logic        regwr;
      logic [4:0]  rd;
      logic [31:0] busw;
      logic        gnt_b;
      logic        busy;
      logic        init_done;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic        m_arb;
   int          m_cnt;
   logic        m_rr_b;
   logic [4:0]  m_rd;
   logic [31:0] m_bus;
   logic        m_gnt;
   logic        a_hs, b_hs;

   regfile_wr_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .clr_req   (clr_req),
      .init_done (init_done),
      .busy      (busy),
      .RegWr     (RegWr),
      .rd        (rd),
      .busW      (busW),
      .gnt_b     (gnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_arb  = 1'b0;
      m_cnt  = 0;
      m_rr_b = 1'b1;
      m_rd   = '0;
      m_bus  = '0;
      m_gnt  = 1'b0;
      sb.delete();
   endtask

   // One clock: called just after a negedge with inputs already driven
   task automatic cycle();
      exp_t e;
      logic ear, ebr;
      #1;
      ear = 1'b0;
      ebr = 1'b0;
      if (m_arb && !clr_req) begin
         ear = a_valid && (!b_valid || m_rr_b);
         ebr = b_valid && !ear;
      end
      check("a_ready", 32'(a_ready), 32'(ear));
      check("b_ready", 32'(b_ready), 32'(ebr));
      a_hs = ear;
      b_hs = ebr;

      e.regwr = 1'b0;
      e.rd    = m_rd;
      e.busw  = m_bus;
      e.gnt_b = m_gnt;
      if (!m_arb) begin
         e.regwr = (m_cnt != 0);
         e.rd    = 5'(m_cnt);
         e.busw  = 32'h0;
         e.gnt_b = 1'b0;
         if (m_cnt == 31) m_arb = 1'b1;
         m_cnt = (m_cnt + 1) % 32;
      end else if (clr_req) begin
         m_arb = 1'b0;
         m_cnt = 0;
      end else if (ear) begin
         e.regwr = (a_addr != 5'd0);
         e.rd    = a_addr;
         e.busw  = a_data;
         e.gnt_b = 1'b0;
         m_rr_b  = 1'b0;
      end else if (ebr) begin
         e.regwr = (b_addr != 5'd0);
         e.rd    = b_addr;
         e.busw  = b_data;
         e.gnt_b = 1'b1;
         m_rr_b  = 1'b1;
      end
      m_rd        = e.rd;
      m_bus       = e.busw;
      m_gnt       = e.gnt_b;
      e.busy      = !m_arb;
      e.init_done = m_arb;
      sb.push_back(e);

      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("RegWr", 32'(RegWr), 32'(e.regwr));
         check("rd", 32'(rd), 32'(e.rd));
         check("busW", busW, e.busw);
         check("gnt_b", 32'(gnt_b), 32'(e.gnt_b));
         check("busy", 32'(busy), 32'(e.busy));
         check("init_done", 32'(init_done), 32'(e.init_done));
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      a_valid = 1'b0;
      b_valid = 1'b0;
      clr_req = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_RegWr"}, 32'(RegWr), 32'd0);
      check({tag, "_rd"}, 32'(rd), 32'd0);
      check({tag, "_busW"}, busW, 32'd0);
      check({tag, "_gnt_b"}, 32'(gnt_b), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_init_done"}, 32'(init_done), 32'd0);
   endtask

   initial begin
      int a_n, b_n, guard;
      rst_n   = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      clr_req = 1'b0;
      a_addr  = '0;
      b_addr  = '0;
      a_data  = '0;
      b_data  = '0;
      a_hs    = 1'b0;
      b_hs    = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      check("rst_a_ready", 32'(a_ready), 32'd0);
      rst_n = 1'b1;

      // Initial sweep, with requests pending to prove readies stay low
      a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h1111_1111;
      b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h2222_2222;
      for (int i = 0; i < 32; i++) begin
         check("sweep_init_done_low", 32'(init_done), 32'd0);
         cycle();
      end
      check("init_done_after_sweep", 32'(init_done), 32'd1);
      a_valid = 1'b0;
      b_valid = 1'b0;

      // Both held valid, each advancing on acceptance: A1,B9,A2,B10
      a_n = 1; b_n = 9;
      a_valid = 1'b1; b_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_addr = 5'(a_n); a_data = 32'hA000_0000 + 32'(a_n);
         b_addr = 5'(b_n); b_data = 32'hB000_0000 + 32'(b_n);
         cycle();
         check("rr_gnt_pattern", 32'(gnt_b), 32'(i % 2));
         if (a_hs) a_n++;
         if (b_hs) b_n++;
      end
      idle(1);

      // A alone: addr 5 DEADBEEF
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
      cycle();
      check("a_alone_rd", 32'(rd), 32'd5);
      idle(2);

      // B to address 0: accepted, not issued; A wins next contest
      b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000_1234;
      cycle();
      check("b_r0_regwr", 32'(RegWr), 32'd0);
      a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h3333_0003;
      b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h4444_0004;
      cycle();
      check("after_r0_a_wins", 32'(gnt_b), 32'd0);
      idle(1);

      // clr_req with a_valid: clear wins, sweep, A accepted after init_done
      a_valid = 1'b1; a_addr = 5'd21; a_data = 32'h2121_2121;
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      check("clr_busy", 32'(busy), 32'd1);
      guard = 0;
      while (!a_hs && guard < 40) begin
         cycle();
         guard++;
      end
      check("clr_a_accepted", 32'(a_hs), 32'd1);
      check("clr_a_wait_cycles", 32'(guard), 32'd33);
      a_valid = 1'b0;
      idle(1);

      // Async reset mid-sweep at address 17, held 3 cycles
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      guard = 0;
      while (rd != 5'd17 && guard < 40) begin
         cycle();
         guard++;
      end
      check("reached_rd17", 32'(rd), 32'd17);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      for (int i = 0; i < 3; i++) @(negedge clk);
      check_reset_outputs("held_rst");
      rst_n = 1'b1;
      idle(32);
      check("resweep_done", 32'(init_done), 32'd1);

      // Random traffic with occasional clears; valid held until accepted
      a_valid = 1'b0;
      b_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!a_valid || a_hs) begin
            a_valid = 1'($urandom_range(0, 1));
            a_addr  = 5'($urandom_range(0, 31));
            a_data  = $urandom;
         end
         if (!b_valid || b_hs) begin
            b_valid = 1'($urandom_range(0, 1));
            b_addr  = 5'($urandom_range(0, 31));
            b_data  = $urandom;
         end
         clr_req = ($urandom_range(0, 39) == 0);
         cycle();
      end
      idle(40);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
